fifo_stream_drain: RTL and testbench

Read-side consumer for the universal synchronous FIFO. It pulls words from the FIFO through its cs/rd_en/empty/data_out interface and presents them on a valid/ready stream, grouped into fixed-length packets with a last flag. A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency, so the stream sustains 1 word/cycle under continuous ready and never loses a word under backpressure.

---
 rtl/fifo_stream_drain.sv | 128 ++++++++++++
 tb/tb_fifo_stream_drain.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_drain.sv
// Read-side drain for a synchronous FIFO: issues credit-limited reads, absorbs the one-cycle
// read latency in a two-entry skid buffer and emits fixed-length packets on a valid/ready stream.
module fifo_stream_drain #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PKT_LEN    = 4,
  localparam int unsigned CNT_W     = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [15:0]           pkt_count,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(PKT_LEN - 1);

  // Skid storage: r_buf0 is always the head, r_buf1 the second entry.
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [CNT_W-1:0]      r_beat;
  logic [15:0]           r_pkt_count;

  logic [DATA_WIDTH-1:0] w_buf0_nxt;
  logic [DATA_WIDTH-1:0] w_buf1_nxt;
  logic [1:0]            w_occ_nxt;
  logic [CNT_W-1:0]      w_beat_nxt;
  logic [15:0]           w_pkt_count_nxt;
  logic [2:0]            w_credit;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_last_beat;

  assign w_credit    = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_push      = r_inflight;
  assign w_pop       = m_valid & m_ready;
  assign w_last_beat = (r_beat == LastBeat);

  assign fifo_cs   = en;
  assign m_valid   = (r_occ != 2'd0);
  assign m_data    = r_buf0;
  assign m_last    = m_valid & w_last_beat;
  assign pkt_count = r_pkt_count;
  assign busy      = (r_occ != 2'd0) | r_inflight;

  // A full credit window may still issue when the head leaves this cycle; this keeps the
  // m_ready -> fifo_rd_en path combinational so a full buffer sustains one word per cycle.
  assign fifo_rd_en = en & ~fifo_empty &
                      ((w_credit < 3'd2) | ((w_credit == 3'd2) & w_pop));

  always_comb begin
    w_buf0_nxt = r_buf0;
    w_buf1_nxt = r_buf1;
    w_occ_nxt  = r_occ;
    case (r_occ)
      2'd0: begin
        if (w_push) begin
          w_buf0_nxt = fifo_data;
          w_occ_nxt  = 2'd1;
        end
      end
      2'd1: begin
        case ({w_push, w_pop})
          2'b11: w_buf0_nxt = fifo_data;
          2'b10: begin
            w_buf1_nxt = fifo_data;
            w_occ_nxt  = 2'd2;
          end
          2'b01: w_occ_nxt = 2'd0;
          default: w_occ_nxt = r_occ;
        endcase
      end
      2'd2: begin
        // Credit accounting rules out a push here without a matching pop.
        if (w_pop) begin
          w_buf0_nxt = r_buf1;
          if (w_push) begin
            w_buf1_nxt = fifo_data;
          end else begin
            w_occ_nxt = 2'd1;
          end
        end
      end
      default: w_occ_nxt = 2'd0;
    endcase
  end

  always_comb begin
    w_beat_nxt      = r_beat;
    w_pkt_count_nxt = r_pkt_count;
    if (w_pop) begin
      if (w_last_beat) begin
        w_beat_nxt      = '0;
        w_pkt_count_nxt = r_pkt_count + 16'd1;
      end else begin
        w_beat_nxt = r_beat + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_occ       <= 2'd0;
      r_inflight  <= 1'b0;
      r_beat      <= '0;
      r_pkt_count <= 16'd0;
    end else begin
      r_buf0      <= w_buf0_nxt;
      r_buf1      <= w_buf1_nxt;
      r_occ       <= w_occ_nxt;
      r_inflight  <= fifo_rd_en;
      r_beat      <= w_beat_nxt;
      r_pkt_count <= w_pkt_count_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain with a behavioural FIFO and a port-level stream monitor.
module tb_fifo_stream_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_cs;
  logic        fifo_rd_en;
  logic        fifo_empty;
  logic [31:0] fifo_data = 32'd0;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic [15:0] pkt_count;
  logic        busy;

  int checks = 0;
  int failures = 0;

  fifo_stream_drain #(.DATA_WIDTH(32), .PKT_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_cs    (fifo_cs),
    .fifo_rd_en (fifo_rd_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .pkt_count  (pkt_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: one-cycle read latency, pointers never rewind.
  logic [31:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_empty_err = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr & 255];
      rd_ptr    <= rd_ptr + 1;
      if (rd_ptr == wr_ptr) rd_empty_err <= rd_empty_err + 1;
    end
  end

  // Stream monitor with an independent occupancy model built from port activity.
  logic        tb_pop;
  int          tb_occ = 0;
  logic        tb_infl = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic        prev_last = 1'b0;
  int          rd_cnt = 0;
  int          valid_err = 0;
  int          stall_err = 0;
  int          ovf_err = 0;
  logic [31:0] rx_data [$];
  logic        rx_last [$];
  assign tb_pop = m_valid & m_ready;

  always @(posedge clk) begin
    if (rst) begin
      tb_occ     <= 0;
      tb_infl    <= 1'b0;
      prev_stall <= 1'b0;
    end else begin
      if (m_valid !== (tb_occ != 0)) valid_err <= valid_err + 1;
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
        stall_err <= stall_err + 1;
      if ((tb_infl && tb_occ == 2 && !tb_pop) || tb_occ > 2) ovf_err <= ovf_err + 1;
      if (tb_pop) begin
        rx_data.push_back(m_data);
        rx_last.push_back(m_last);
      end
      if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
      tb_occ     <= tb_occ + (tb_infl ? 1 : 0) - (tb_pop ? 1 : 0);
      tb_infl    <= fifo_rd_en;
      prev_stall <= m_valid & ~m_ready;
      prev_data  <= m_data;
      prev_last  <= m_last;
    end
  end

  task automatic push_words(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr & 255] = first + 32'(i);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", m_valid); end
    checks++; if (m_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%0h want=0", m_data); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%0b want=0", m_last); end
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%0b want=0", fifo_rd_en); end
    checks++; if (pkt_count !== 16'd0) begin failures++; $display("FAIL reset_pkt got=%0d want=0", pkt_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int rx0;
    int rd0;
    @(negedge clk);
    push_words(32'd1, 8); en = 1'b1; m_ready = 1'b1;
    rx0 = rx_data.size(); rd0 = rd_cnt;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (fifo_rd_en !== (c < 8)) begin failures++; $display("FAIL basic_rd_en c=%0d got=%0b want=%0b", c, fifo_rd_en, (c < 8)); end
      checks++; if (m_valid !== (c >= 2 && c <= 9)) begin failures++; $display("FAIL basic_valid c=%0d got=%0b", c, m_valid); end
      if (c >= 2 && c <= 9) begin
        checks++; if (m_data !== 32'(c - 1)) begin failures++; $display("FAIL basic_data c=%0d got=%0d want=%0d", c, m_data, c - 1); end
        checks++; if (m_last !== ((c - 1) % 4 == 0)) begin failures++; $display("FAIL basic_last c=%0d got=%0b", c, m_last); end
      end
      checks++; if (busy !== (c >= 1 && c <= 9)) begin failures++; $display("FAIL basic_busy c=%0d got=%0b", c, busy); end
    end
    checks++; if (fifo_cs !== 1'b1) begin failures++; $display("FAIL basic_cs got=%0b want=1", fifo_cs); end
    checks++; if (pkt_count !== 16'd2) begin failures++; $display("FAIL basic_pkt got=%0d want=2", pkt_count); end
    checks++; if (rd_cnt - rd0 !== 8) begin failures++; $display("FAIL basic_rd_cnt got=%0d want=8", rd_cnt - rd0); end
    checks++; if (rx_data.size() - rx0 !== 8) begin failures++; $display("FAIL basic_rx_cnt got=%0d want=8", rx_data.size() - rx0); end
  endtask

  task automatic test_backpressure();
    int rx0;
    int rd0;
    logic [31:0] want;
    @(negedge clk);
    m_ready = 1'b0; en = 1'b1; push_words(32'd101, 8);
    rx0 = rx_data.size(); rd0 = rd_cnt;
    repeat (9) @(negedge clk);
    #1;
    checks++; if (rd_cnt - rd0 !== 2) begin failures++; $display("FAIL bp_rd_cnt got=%0d want=2", rd_cnt - rd0); end
    checks++; if (dut.r_occ !== 2'd2) begin failures++; $display("FAIL bp_occ got=%0d want=2", dut.r_occ); end
    checks++; if (wr_ptr - rd_ptr !== 6) begin failures++; $display("FAIL bp_fifo_level got=%0d want=6", wr_ptr - rd_ptr); end
    checks++; if (m_valid !== 1'b1 || m_data !== 32'd101) begin failures++; $display("FAIL bp_head got=%0b/%0d want=1/101", m_valid, m_data); end
    @(negedge clk);
    m_ready = 1'b1;
    repeat (14) @(negedge clk);
    #1;
    checks++; if (rx_data.size() - rx0 !== 8) begin failures++; $display("FAIL bp_rx_cnt got=%0d want=8", rx_data.size() - rx0); end
    else begin
      for (int i = 0; i < 8; i++) begin
        want = 32'(101 + i);
        checks++; if (rx_data[rx0 + i] !== want) begin failures++; $display("FAIL bp_data i=%0d got=%0d want=%0d", i, rx_data[rx0 + i], want); end
        checks++; if (rx_last[rx0 + i] !== (i % 4 == 3)) begin failures++; $display("FAIL bp_last i=%0d got=%0b", i, rx_last[rx0 + i]); end
      end
    end
    checks++; if (pkt_count !== 16'd4) begin failures++; $display("FAIL bp_pkt got=%0d want=4", pkt_count); end
  endtask

  task automatic test_enable_pause();
    int rx0;
    int rd0;
    logic [31:0] want;
    @(negedge clk);
    push_words(32'd201, 8); m_ready = 1'b1;
    rx0 = rx_data.size(); rd0 = rd_cnt;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      en = (c < 3);
      #1;
      checks++; if (fifo_rd_en !== (c < 3)) begin failures++; $display("FAIL pause_rd_en c=%0d got=%0b", c, fifo_rd_en); end
      if (m_valid) begin
        checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL pause_last_early c=%0d got=1 want=0", c); end
      end
    end
    checks++; if (rd_cnt - rd0 !== 3) begin failures++; $display("FAIL pause_rd_cnt got=%0d want=3", rd_cnt - rd0); end
    checks++; if (rx_data.size() - rx0 !== 3) begin failures++; $display("FAIL pause_rx_cnt got=%0d want=3", rx_data.size() - rx0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pause_busy got=%0b want=0", busy); end
    @(negedge clk);
    en = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    checks++; if (rx_data.size() - rx0 !== 8) begin failures++; $display("FAIL pause_total got=%0d want=8", rx_data.size() - rx0); end
    else begin
      for (int i = 0; i < 8; i++) begin
        want = 32'(201 + i);
        checks++; if (rx_data[rx0 + i] !== want) begin failures++; $display("FAIL pause_data i=%0d got=%0d want=%0d", i, rx_data[rx0 + i], want); end
        checks++; if (rx_last[rx0 + i] !== (i == 3 || i == 7)) begin failures++; $display("FAIL pause_last i=%0d got=%0b", i, rx_last[rx0 + i]); end
      end
    end
    checks++; if (pkt_count !== 16'd6) begin failures++; $display("FAIL pause_pkt got=%0d want=6", pkt_count); end
  endtask

  task automatic test_random_ready();
    int rx0;
    int st0;
    int cyc;
    @(negedge clk);
    push_words(32'd0, 32); en = 1'b1;
    rx0 = rx_data.size(); st0 = stall_err; cyc = 0;
    while (rx_data.size() - rx0 < 32 && cyc < 400) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b1;
    #1;
    checks++; if (rx_data.size() - rx0 !== 32) begin failures++; $display("FAIL rand_rx_cnt got=%0d want=32 (cycle budget)", rx_data.size() - rx0); end
    else begin
      for (int i = 0; i < 32; i++) begin
        checks++; if (rx_data[rx0 + i] !== 32'(i)) begin failures++; $display("FAIL rand_data i=%0d got=%0d", i, rx_data[rx0 + i]); end
        checks++; if (rx_last[rx0 + i] !== (i % 4 == 3)) begin failures++; $display("FAIL rand_last i=%0d got=%0b", i, rx_last[rx0 + i]); end
      end
    end
    checks++; if (stall_err - st0 !== 0) begin failures++; $display("FAIL rand_stall_stable got=%0d want=0", stall_err - st0); end
    checks++; if (pkt_count !== 16'd14) begin failures++; $display("FAIL rand_pkt got=%0d want=14", pkt_count); end
  endtask

  task automatic test_empty_guard();
    int rd0;
    @(negedge clk);
    en = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin failures++; $display("FAIL empty_idle c=%0d rd_en=%0b valid=%0b want=0/0", c, fifo_rd_en, m_valid); end
    end
    @(negedge clk);
    push_words(32'd42, 1);
    rd0 = rd_cnt;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (fifo_rd_en !== (c == 0)) begin failures++; $display("FAIL empty_rd_en c=%0d got=%0b", c, fifo_rd_en); end
      checks++; if (m_valid !== (c == 2)) begin failures++; $display("FAIL empty_valid c=%0d got=%0b", c, m_valid); end
      if (c == 2) begin
        checks++; if (m_data !== 32'd42) begin failures++; $display("FAIL empty_data got=%0d want=42", m_data); end
      end
    end
    checks++; if (rd_cnt - rd0 !== 1) begin failures++; $display("FAIL empty_rd_cnt got=%0d want=1", rd_cnt - rd0); end
  endtask

  task automatic test_reset_midstream();
    int rx0;
    logic [31:0] want;
    @(negedge clk);
    push_words(32'd301, 8); en = 1'b1; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 32'd301) begin failures++; $display("FAIL rstmid_head got=%0b/%0d want=1/301", m_valid, m_data); end
    @(negedge clk);
    rst = 1'b1; m_ready = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b1 || dut.r_occ !== 2'd2) begin failures++; $display("FAIL rstmid_setup rd_en=%0b occ=%0d want=1/2", fifo_rd_en, dut.r_occ); end
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || m_data !== 32'd0 || m_last !== 1'b0) begin failures++; $display("FAIL rstmid_stream got=%0b/%0d/%0b want=0/0/0", m_valid, m_data, m_last); end
    checks++; if (fifo_rd_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_ctl rd_en=%0b busy=%0b want=0/0", fifo_rd_en, busy); end
    checks++; if (pkt_count !== 16'd0) begin failures++; $display("FAIL rstmid_pkt got=%0d want=0", pkt_count); end
    rx0 = rx_data.size();
    @(negedge clk);
    en = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    // 301/302 were buffered and 303 was in flight at reset; all three are gone.
    checks++; if (rx_data.size() - rx0 !== 5) begin failures++; $display("FAIL rstmid_rx_cnt got=%0d want=5", rx_data.size() - rx0); end
    else begin
      for (int i = 0; i < 5; i++) begin
        want = 32'(304 + i);
        checks++; if (rx_data[rx0 + i] !== want) begin failures++; $display("FAIL rstmid_data i=%0d got=%0d want=%0d", i, rx_data[rx0 + i], want); end
        checks++; if (rx_last[rx0 + i] !== (i == 3)) begin failures++; $display("FAIL rstmid_last i=%0d got=%0b", i, rx_last[rx0 + i]); end
      end
    end
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL rstmid_pkt_end got=%0d want=1", pkt_count); end
  endtask

  task automatic test_invariants();
    checks++; if (ovf_err !== 0) begin failures++; $display("FAIL inv_skid_overflow got=%0d want=0", ovf_err); end
    checks++; if (valid_err !== 0) begin failures++; $display("FAIL inv_valid_vs_occ got=%0d want=0", valid_err); end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL inv_stall_stable got=%0d want=0", stall_err); end
    checks++; if (rd_empty_err !== 0) begin failures++; $display("FAIL inv_rd_when_empty got=%0d want=0", rd_empty_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_enable_pause();
    test_random_ready();
    test_empty_guard();
    test_reset_midstream();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
